// File: rtl/full_handshake_rx_pkg.sv
// Shared types for the 4-phase handshake receiver: FSM state encoding and buffer helpers.
// Optional feature macro used by the receiver: FULL_HANDSHAKE_RX_TIMEOUT_EN.
package full_handshake_rx_pkg;

  // One-hot RX FSM encoding; any other value is treated as illegal and recovers to idle.
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'b01,
    STATE_ASSERT = 2'b10
  } rx_state_e;

  // The output buffer can take a new word when empty or when being drained this cycle.
  function automatic logic buf_space(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Reset-to-0 multi-flop synchroniser for a single asynchronous bit.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/full_handshake_rx.sv
// Receive side of a 4-phase CDC handshake; buffers the word on a valid/ready interface.
// Optional ack-timeout flag enabled by defining FULL_HANDSHAKE_RX_TIMEOUT_EN.
module full_handshake_rx
  import full_handshake_rx_pkg::*;
#(
`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 1024,
`endif
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [DW-1:0] req_data_i,
  output logic          ack_o,
  output logic          recv_valid_o,
  output logic [DW-1:0] recv_data_o,
  input  logic          recv_ready_i,
  output logic          idle_o
`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
  ,
  output logic          timeout_o
`endif
);

  rx_state_e     state_q;
  rx_state_e     state_d;
  logic          req_sync;
  logic          space_c;
  logic          capture_c;
  logic          ack_d;
  logic          valid_d;
  logic [DW-1:0] data_d;
  logic          idle_d;

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d_i(req_i),
    .q_o(req_sync)
  );

  assign space_c = buf_space(recv_valid_o, recv_ready_i);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ack is withheld while the buffer is full, which back-pressures TX.
  always_comb begin
    state_d = STATE_IDLE;
    case (state_q)
      STATE_IDLE: begin
        if (req_sync && space_c) begin
          state_d = STATE_ASSERT;
        end
      end
      STATE_ASSERT: begin
        state_d = req_sync ? STATE_ASSERT : STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Output decode: a capture wins over a simultaneous drain of the previous word.
  always_comb begin
    capture_c = (state_q == STATE_IDLE) && (state_d == STATE_ASSERT);
    ack_d     = (state_d == STATE_ASSERT);
    valid_d   = recv_valid_o;
    data_d    = recv_data_o;
    if (capture_c) begin
      valid_d = 1'b1;
      data_d  = req_data_i;
    end else if (recv_valid_o && recv_ready_i) begin
      valid_d = 1'b0;
    end
    idle_d = (state_d == STATE_IDLE) && !valid_d;
  end

  // All outputs come straight from flops so ack is glitch-free toward TX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o        <= 1'b0;
      recv_valid_o <= 1'b0;
      recv_data_o  <= '0;
      idle_o       <= 1'b1;
    end else begin
      ack_o        <= ack_d;
      recv_valid_o <= valid_d;
      recv_data_o  <= data_d;
      idle_o       <= idle_d;
    end
  end

`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt_q;

  // Saturating count of ack-high cycles; flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (capture_c) begin
        to_cnt_q <= '0;
      end else if ((state_q == STATE_ASSERT) && (to_cnt_q != TW'(TIMEOUT_CYC))) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
      if ((state_q == STATE_ASSERT) && (to_cnt_q >= TW'(TIMEOUT_CYC - 1))) begin
        timeout_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_full_handshake_rx.sv
// Self-checking bench for full_handshake_rx: cycle vector table, corner sequences, random traffic.
// Timeout sequence is included when FULL_HANDSHAKE_RX_TIMEOUT_EN is defined.
module tb_full_handshake_rx;

  localparam int unsigned DW   = 32;
  localparam int unsigned SYNC = 2;

  logic          clk;
  logic          rst;
  logic          req;
  logic [DW-1:0] req_data;
  logic          ack;
  logic          recv_valid;
  logic [DW-1:0] recv_data;
  logic          recv_ready;
  logic          idle;
`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
  logic          timeout;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic          mon_en = 1'b0;
  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_q[$];
  logic          tx_done;

  typedef struct {
    logic          rst;
    logic          req;
    logic [DW-1:0] data;
    logic          ready;
    logic          ack;
    logic          valid;
    logic [DW-1:0] rdata;
    logic          idle;
  } vec_t;

  vec_t vecs[$];

  full_handshake_rx #(
`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
    .TIMEOUT_CYC(8),
`endif
    .DW(DW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .req_data_i(req_data),
    .ack_o(ack),
    .recv_valid_o(recv_valid),
    .recv_data_o(recv_data),
    .recv_ready_i(recv_ready),
    .idle_o(idle)
`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words accepted by the consumer: valid & ready as seen mid-cycle are taken at the next edge.
  always @(negedge clk) begin
    if (mon_en && recv_valid === 1'b1 && recv_ready === 1'b1) got.push_back(recv_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic add_vec(input logic r, input logic q, input logic [DW-1:0] d, input logic rdy,
                         input logic a, input logic v, input logic [DW-1:0] rd, input logic i);
    vec_t t;
    t.rst = r; t.req = q; t.data = d; t.ready = rdy;
    t.ack = a; t.valid = v; t.rdata = rd; t.idle = i;
    vecs.push_back(t);
  endtask

  // TX side of the protocol: present word, raise req, wait ack, drop req, wait ack low.
  task automatic send_word(input logic [DW-1:0] d);
    int n;
    req_data = d;
    req      = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 200) begin tick(); n++; end
    check("ack_rise_in_budget", 32'(n < 200), 32'd1);
    check("ack_rise_latency_min", 32'(n >= int'(SYNC) + 1), 32'd1);
    req = 1'b0;
    n = 0;
    while (ack !== 1'b0 && n < 20) begin tick(); n++; end
    check("ack_fall_latency", 32'(n), 32'(SYNC + 1));
  endtask

  task automatic compare_rx(input string nm);
    int n;
    check({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({nm, "_word"}, got[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; req = 1'b1; req_data = 32'hDEADBEEF; recv_ready = 1'b1; tx_done = 1'b0;

    // Cycle table: reset with req high, single word, then drain+capture in one cycle.
    //      rst   req   data          rdy   ack   val   rdata         idle
    add_vec(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1);
    add_vec(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1);
    add_vec(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1);
    add_vec(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1);
    add_vec(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1);
    add_vec(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    add_vec(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    add_vec(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    add_vec(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    add_vec(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    add_vec(1'b0, 1'b1, 32'hA,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    add_vec(1'b0, 1'b1, 32'hA,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    add_vec(1'b0, 1'b1, 32'hA,        1'b0, 1'b1, 1'b1, 32'hA,        1'b0);
    add_vec(1'b0, 1'b0, 32'hA,        1'b0, 1'b1, 1'b1, 32'hA,        1'b0);
    add_vec(1'b0, 1'b0, 32'hA,        1'b0, 1'b1, 1'b1, 32'hA,        1'b0);
    add_vec(1'b0, 1'b0, 32'hA,        1'b0, 1'b0, 1'b1, 32'hA,        1'b0);
    add_vec(1'b0, 1'b1, 32'hB,        1'b0, 1'b0, 1'b1, 32'hA,        1'b0);
    add_vec(1'b0, 1'b1, 32'hB,        1'b0, 1'b0, 1'b1, 32'hA,        1'b0);
    add_vec(1'b0, 1'b1, 32'hB,        1'b1, 1'b1, 1'b1, 32'hB,        1'b0);
    add_vec(1'b0, 1'b1, 32'hB,        1'b0, 1'b1, 1'b1, 32'hB,        1'b0);
    add_vec(1'b0, 1'b0, 32'hB,        1'b1, 1'b1, 1'b0, 32'hB,        1'b0);
    add_vec(1'b0, 1'b0, 32'hB,        1'b0, 1'b1, 1'b0, 32'hB,        1'b0);
    add_vec(1'b0, 1'b0, 32'hB,        1'b0, 1'b0, 1'b0, 32'hB,        1'b1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; req_data = vecs[i].data; recv_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_ack", i),   32'(ack),        32'(vecs[i].ack));
      check($sformatf("vec%0d_valid", i), 32'(recv_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_data", i),  recv_data,       vecs[i].rdata);
      check($sformatf("vec%0d_idle", i),  32'(idle),       32'(vecs[i].idle));
    end

    // Back-pressure: second word must not be acked until the first is consumed.
    got.delete(); exp_q.delete(); mon_en = 1'b1;
    recv_ready = 1'b0;
    send_word(32'h1);
    req_data = 32'h2; req = 1'b1;
    repeat (10) tick();
    check("bp_ack_withheld", 32'(ack), 32'd0);
    check("bp_valid_held", 32'(recv_valid), 32'd1);
    check("bp_data_held", recv_data, 32'h1);
    recv_ready = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 50) begin tick(); n++; end
    check("bp_ack_after_drain", 32'(ack), 32'd1);
    req = 1'b0;
    n = 0;
    while (ack !== 1'b0 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    compare_rx("bp_rx");
    mon_en = 1'b0;

    // Randomized traffic with a randomly stalling consumer; order and count must be exact.
    got.delete(); exp_q.delete(); mon_en = 1'b1;
    fork
      begin
        for (int w = 0; w < 40; w++) begin
          logic [DW-1:0] d;
          d = $urandom;
          exp_q.push_back(d);
          send_word(d);
          repeat ($urandom_range(0, 3)) tick();
        end
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          recv_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    recv_ready = 1'b1;
    repeat (5) tick();
    compare_rx("rand_rx");
    check("rand_idle_end", 32'(idle), 32'd1);
    mon_en = 1'b0;

    // Reset while ack is high: ack and valid drop at the next edge, TX then finishes cleanly.
    recv_ready = 1'b0; req_data = 32'h5; req = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 50) begin tick(); n++; end
    check("mrst_ack_before", 32'(ack), 32'd1);
    req = 1'b0; rst = 1'b1;
    tick();
    check("mrst_ack", 32'(ack), 32'd0);
    check("mrst_valid", 32'(recv_valid), 32'd0);
    check("mrst_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    repeat (6) tick();
    check("mrst_after_ack", 32'(ack), 32'd0);
    check("mrst_after_valid", 32'(recv_valid), 32'd0);
    check("mrst_after_idle", 32'(idle), 32'd1);

`ifdef FULL_HANDSHAKE_RX_TIMEOUT_EN
    // Ack held high past the timeout threshold sets a sticky flag.
    check("to_clear_after_reset", 32'(timeout), 32'd0);
    recv_ready = 1'b1; req_data = 32'h7; req = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    check("to_not_yet", 32'(timeout), 32'd0);
    repeat (17) tick();
    check("to_set", 32'(timeout), 32'd1);
    req = 1'b0;
    repeat (6) tick();
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_ack_released", 32'(ack), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
